// File: rtl/adder_tree_arbiter_if.sv
// Requester, tree and response signals of the shared adder-tree front end.
// master = arbiter side, slave = requesters + tree + response consumer.
interface adder_tree_arbiter_if #(
  parameter int NB_REQ    = 4,
  parameter int NB_IN     = 8,
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = IN_WIDTH + NB_IN,
  parameter int ID_WIDTH  = (NB_REQ > 1) ? $clog2(NB_REQ) : 1
);
  logic [NB_REQ-1:0]                req_valid;
  logic [NB_REQ-1:0]                req_ready;
  logic [NB_REQ*NB_IN*IN_WIDTH-1:0] req_data;
  logic [NB_IN*IN_WIDTH-1:0]        tree_data_in;
  logic                             tree_data_in_en;
  logic [OUT_WIDTH-1:0]             tree_data_out;
  logic                             tree_data_out_en;
  logic [OUT_WIDTH-1:0]             rsp_data;
  logic [ID_WIDTH-1:0]              rsp_id;
  logic                             rsp_valid;

  modport master (
    input  req_valid, req_data, tree_data_out, tree_data_out_en,
    output req_ready, tree_data_in, tree_data_in_en, rsp_data, rsp_id, rsp_valid
  );

  modport slave (
    output req_valid, req_data, tree_data_out, tree_data_out_en,
    input  req_ready, tree_data_in, tree_data_in_en, rsp_data, rsp_id, rsp_valid
  );
endinterface

// File: rtl/adder_tree_arbiter.sv
// Round-robin share of one adder tree: vector reaches the tree 1 cycle after handshake, response 1 cycle after the tree strobe.
// Backpressure: req_ready held low while MAX_OUTSTANDING vectors are in flight; responses cannot be stalled.

module sync_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_vld,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop_vld,
  output logic [WIDTH-1:0]       pop_dat,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_vld) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_vld) rd_ptr <= rd_ptr + 1'b1;
      case ({push_vld, pop_vld})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign pop_dat = mem[rd_ptr];
  assign empty   = (cnt == '0);
  assign count   = cnt;
endmodule

module adder_tree_arbiter #(
  parameter int NB_REQ          = 4,
  parameter int NB_IN           = 8,
  parameter int IN_WIDTH        = 16,
  parameter int OUT_WIDTH       = IN_WIDTH + NB_IN,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ID_WIDTH        = (NB_REQ > 1) ? $clog2(NB_REQ) : 1
) (
  input  logic                               clk,
  input  logic                               reset,
  adder_tree_arbiter_if.master               bus,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               busy,
  output logic                               err_orphan
);
  localparam int VEC_W = NB_IN * IN_WIDTH;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  logic [ID_WIDTH-1:0] rr_ptr;
  logic [ID_WIDTH-1:0] gnt_id;
  logic [ID_WIDTH-1:0] pop_id;
  logic [CNT_W-1:0]    fifo_cnt;
  logic                fifo_empty;
  logic                gnt_found;
  logic                eligible;
  logic                xfer;
  logic                rsp_fire;

  // Credit check uses the registered count, so a slot freed this cycle is only reusable next cycle.
  assign eligible = (fifo_cnt < CNT_W'(MAX_OUTSTANDING));

  always_comb begin
    int                  idx;
    logic [ID_WIDTH-1:0] cand;
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = 0;
    cand      = '0;
    for (int k = 0; k < NB_REQ; k++) begin
      idx  = (int'(rr_ptr) + k) % NB_REQ;
      cand = ID_WIDTH'(idx);
      if (!gnt_found && bus.req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = cand;
      end
    end
  end

  assign xfer     = !reset && eligible && gnt_found;
  assign rsp_fire = bus.tree_data_out_en && !fifo_empty;

  always_comb begin
    bus.req_ready = '0;
    if (xfer) bus.req_ready[gnt_id] = 1'b1;
  end

  sync_fifo #(
    .WIDTH (ID_WIDTH),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (xfer),
    .push_dat (gnt_id),
    .pop_vld  (rsp_fire),
    .pop_dat  (pop_id),
    .empty    (fifo_empty),
    .count    (fifo_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr              <= '0;
      bus.tree_data_in    <= '0;
      bus.tree_data_in_en <= 1'b0;
      bus.rsp_data        <= '0;
      bus.rsp_id          <= '0;
      bus.rsp_valid       <= 1'b0;
      err_orphan          <= 1'b0;
    end else begin
      bus.tree_data_in_en <= xfer;
      if (xfer) begin
        bus.tree_data_in <= bus.req_data[gnt_id*VEC_W +: VEC_W];
        rr_ptr           <= (gnt_id == ID_WIDTH'(NB_REQ - 1)) ? '0 : gnt_id + 1'b1;
      end
      bus.rsp_valid <= rsp_fire;
      if (rsp_fire) begin
        bus.rsp_data <= OUT_WIDTH'(bus.tree_data_out);
        bus.rsp_id   <= pop_id;
      end
      // A result with no recorded issuer means the tree and this block disagree; latch it.
      if (bus.tree_data_out_en && fifo_empty) err_orphan <= 1'b1;
    end
  end

  assign outstanding = fifo_cnt;
  assign busy        = (fifo_cnt != '0) || bus.tree_data_in_en;
endmodule

// File: tb/tb_adder_tree_arbiter.sv
// Bench for adder_tree_arbiter: registered-sum tree of latency lat, per-cycle reference model of grants,
// credits and the in-flight queue, plus directed checks on order, latency, fairness, orphan and reset.
module tb_adder_tree_arbiter;
  localparam int NB_REQ    = 4;
  localparam int NB_IN     = 4;
  localparam int IN_WIDTH  = 8;
  localparam int OUT_WIDTH = 12;
  localparam int MAX_OUT   = 4;
  localparam int ID_WIDTH  = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] outstanding;
  logic       busy;
  logic       err_orphan;

  always #5 clk = ~clk;

  adder_tree_arbiter_if #(
    .NB_REQ(NB_REQ), .NB_IN(NB_IN), .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .ID_WIDTH(ID_WIDTH)
  ) bus ();

  adder_tree_arbiter #(
    .NB_REQ(NB_REQ), .NB_IN(NB_IN), .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH),
    .MAX_OUTSTANDING(MAX_OUT), .ID_WIDTH(ID_WIDTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .outstanding (outstanding),
    .busy        (busy),
    .err_orphan  (err_orphan)
  );

  // Requester operand storage
  logic [7:0] ops [NB_REQ][NB_IN];

  always_comb begin
    bus.req_data = '0;
    for (int r = 0; r < NB_REQ; r++)
      for (int i = 0; i < NB_IN; i++)
        bus.req_data[(r*NB_IN+i)*IN_WIDTH +: IN_WIDTH] = ops[r][i];
  end

  // Bench adder tree: registered sum with latency lat (1..5), reset together with the DUT
  int          lat;
  logic        orphan_inj;
  logic        pipe_en  [5];
  logic [11:0] pipe_sum [5];

  function automatic logic [11:0] tree_sum(input logic [31:0] v);
    logic [11:0] s;
    s = '0;
    for (int i = 0; i < NB_IN; i++) s = s + 12'(v[i*8 +: 8]);
    return s;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 5; i++) begin
        pipe_en[i]  <= 1'b0;
        pipe_sum[i] <= '0;
      end
    end else begin
      pipe_en[0]  <= bus.tree_data_in_en;
      pipe_sum[0] <= tree_sum(bus.tree_data_in);
      for (int i = 1; i < 5; i++) begin
        pipe_en[i]  <= pipe_en[i-1];
        pipe_sum[i] <= pipe_sum[i-1];
      end
    end
  end

  assign bus.tree_data_out_en = pipe_en[lat-1] | orphan_inj;
  assign bus.tree_data_out    = pipe_sum[lat-1];

  // Reference model
  typedef struct {int id; int sum;} ent_t;
  ent_t        q[$];
  int          m_rr;
  bit          m_rsp_v;
  int          m_rsp_id;
  int          m_rsp_data;
  bit          m_err;
  bit          m_tin_en;
  logic [31:0] m_tin;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int g_cyc[$], g_id[$], r_cyc[$], r_id[$], r_dat[$];
  int max_out;

  logic [3:0] en_mask;
  bit         one_shot;
  bit         rand_mode;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ops_sum(input int r);
    int s;
    s = 0;
    for (int i = 0; i < NB_IN; i++) s += int'(ops[r][i]);
    return s;
  endfunction

  function automatic logic [31:0] ops_vec(input int r);
    logic [31:0] v;
    for (int i = 0; i < NB_IN; i++) v[i*8 +: 8] = ops[r][i];
    return v;
  endfunction

  task automatic rand_ops(input int r);
    for (int i = 0; i < NB_IN; i++) ops[r][i] = 8'($urandom_range(0, 255));
  endtask

  task automatic model_clear();
    q.delete();
    m_rr = 0; m_rsp_v = 0; m_rsp_id = 0; m_rsp_data = 0; m_err = 0; m_tin_en = 0; m_tin = '0;
  endtask

  task automatic clr_logs();
    g_cyc.delete(); g_id.delete(); r_cyc.delete(); r_id.delete(); r_dat.delete();
    max_out = 0;
  endtask

  // One clock: predict, compare at negedge, advance the model, then refresh requesters after the edge.
  task automatic tick();
    int   g;
    int   gi;
    logic [3:0] exp_rdy;
    ent_t e;
    logic oe;
    g = -1;
    if (!reset && q.size() < MAX_OUT)
      for (int k = 0; k < NB_REQ; k++) begin
        int r;
        r = (m_rr + k) % NB_REQ;
        if (g < 0 && bus.req_valid[r]) g = r;
      end
    exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0;
    @(negedge clk);
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    chk("outstanding", 32'(outstanding), q.size());
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_rsp_v));
    if (m_rsp_v) begin
      chk("rsp_id", 32'(bus.rsp_id), m_rsp_id);
      chk("rsp_data", 32'(bus.rsp_data), m_rsp_data);
    end
    chk("tree_in_en", 32'(bus.tree_data_in_en), 32'(m_tin_en));
    if (m_tin_en) chk("tree_in", bus.tree_data_in, m_tin);
    chk("err_orphan", 32'(err_orphan), 32'(m_err));
    chk("busy", 32'(busy), 32'(q.size() != 0 || m_tin_en));
    gi = -1;
    for (int r = 0; r < NB_REQ; r++) if (bus.req_ready[r] === 1'b1) gi = r;
    if (gi >= 0) begin g_cyc.push_back(cyc); g_id.push_back(gi); end
    if (bus.rsp_valid === 1'b1) begin
      r_cyc.push_back(cyc); r_id.push_back(int'(bus.rsp_id)); r_dat.push_back(int'(bus.rsp_data));
    end
    if (int'(outstanding) > max_out) max_out = int'(outstanding);
    oe = bus.tree_data_out_en;
    if (reset) model_clear();
    else begin
      m_rsp_v = 0;
      if (oe) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          m_rsp_v = 1; m_rsp_id = e.id; m_rsp_data = e.sum;
        end else m_err = 1;
      end
      m_tin_en = (g >= 0);
      if (g >= 0) begin
        e.id = g; e.sum = ops_sum(g);
        q.push_back(e);
        m_tin = ops_vec(g);
        m_rr  = (g + 1) % NB_REQ;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (g >= 0) begin
      rand_ops(g);
      bus.req_valid[g] = one_shot ? 1'b0 : (rand_mode ? 1'($urandom_range(0, 1)) : en_mask[g]);
    end
    if (rand_mode)
      for (int r = 0; r < NB_REQ; r++)
        if (!bus.req_valid[r] && $urandom_range(0, 2) == 0) begin
          rand_ops(r);
          bus.req_valid[r] = 1'b1;
        end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(bus.req_ready), 0);
    chk({tag, "_tin_en"}, 32'(bus.tree_data_in_en), 0);
    chk({tag, "_tin"}, bus.tree_data_in, 0);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
    chk({tag, "_rsp_data"}, 32'(bus.rsp_data), 0);
    chk({tag, "_rsp_id"}, 32'(bus.rsp_id), 0);
    chk({tag, "_outstanding"}, 32'(outstanding), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_err"}, 32'(err_orphan), 0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    tick();
    check_reset_outputs(tag);
    reset = 1'b0;
    clr_logs();
  endtask

  initial begin
    reset = 1'b1; bus.req_valid = '0; lat = 1; orphan_inj = 1'b0;
    en_mask = '0; one_shot = 1'b0; rand_mode = 1'b0;
    for (int r = 0; r < NB_REQ; r++) rand_ops(r);
    model_clear();
    clr_logs();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst0");
    reset = 1'b0;

    // Single request from requester 1, operands 1,2,3,4
    lat = 1; one_shot = 1'b1;
    ops[1][0] = 8'd1; ops[1][1] = 8'd2; ops[1][2] = 8'd3; ops[1][3] = 8'd4;
    bus.req_valid = 4'b0010;
    repeat (6) tick();
    chk("single_ngrants", g_id.size(), 1);
    chk("single_nrsp", r_id.size(), 1);
    if (g_id.size() > 0 && r_id.size() > 0) begin
      chk("single_gnt_id", g_id[0], 1);
      chk("single_rsp_id", r_id[0], 1);
      chk("single_rsp_data", r_dat[0], 10);
      chk("single_latency", r_cyc[0] - g_cyc[0], 3);
    end

    // Round-robin with all requesters valid
    do_reset("rst1");
    one_shot = 1'b0; en_mask = 4'b1111; bus.req_valid = 4'b1111;
    repeat (20) tick();
    bus.req_valid = '0;
    repeat (4) tick();
    chk("rr_ngrants", g_id.size(), 20);
    for (int k = 0; k < 8 && k < g_id.size() && k < r_id.size(); k++) begin
      chk("rr_gnt_order", g_id[k], k % NB_REQ);
      chk("rr_no_gap", g_cyc[k] - g_cyc[0], k);
      chk("rr_rsp_order", r_id[k], k % NB_REQ);
    end

    // Credit stall with a slow tree
    do_reset("rst2");
    lat = 5; bus.req_valid = 4'b1111;
    repeat (30) tick();
    bus.req_valid = '0;
    repeat (10) tick();
    chk("credit_max_out", max_out, MAX_OUT);
    if (g_cyc.size() > 4 && r_cyc.size() > 0) begin
      chk("credit_burst", g_cyc[3] - g_cyc[0], 3);
      chk("credit_resume", g_cyc[4] - g_cyc[0], lat + 2);
      chk("credit_first_rsp", r_cyc[0] - g_cyc[0], lat + 2);
    end else chk("credit_ngrants", g_cyc.size(), 30);

    // Fairness: rr_ptr moved to 1, then requesters 3 and 0 compete
    do_reset("rst3");
    lat = 1; one_shot = 1'b1; bus.req_valid = 4'b0001;
    tick();
    one_shot = 1'b0; en_mask = 4'b1001; bus.req_valid = 4'b1001;
    repeat (8) tick();
    bus.req_valid = '0;
    repeat (4) tick();
    chk("fair_ngrants", g_id.size(), 9);
    for (int k = 1; k < 5 && k < g_id.size(); k++)
      chk("fair_order", g_id[k], (k % 2 == 1) ? 3 : 0);

    // Orphan result, then reset in the middle of a burst
    do_reset("rst4");
    orphan_inj = 1'b1;
    tick();
    orphan_inj = 1'b0;
    repeat (2) tick();
    chk("orphan_err", 32'(err_orphan), 1);
    chk("orphan_no_rsp", r_id.size(), 0);
    lat = 5; en_mask = 4'b1111; bus.req_valid = 4'b1111;
    repeat (5) tick();
    do_reset("rst_mid");
    bus.req_valid = '0;
    repeat (8) tick();
    chk("post_reset_no_rsp", r_id.size(), 0);

    // All-ones operands
    lat = 1; one_shot = 1'b1;
    for (int i = 0; i < NB_IN; i++) ops[2][i] = 8'hFF;
    bus.req_valid = 4'b0100;
    repeat (6) tick();
    chk("max_nrsp", r_id.size(), 1);
    if (r_id.size() > 0) begin
      chk("max_rsp_data", r_dat[0], 32'h3FC);
      chk("max_rsp_id", r_id[0], 2);
    end

    // Random traffic
    do_reset("rst5");
    one_shot = 1'b0; rand_mode = 1'b1; lat = 3;
    repeat (400) tick();
    rand_mode = 1'b0; bus.req_valid = '0;
    repeat (10) tick();
    chk("rand_drained", 32'(outstanding), 0);
    chk("rand_no_orphan", 32'(err_orphan), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
